// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with valid/ready handshakes on both sides.
// Single-cycle ops (ADD..NOR) complete on the accepting edge and wait in HOLD
// until the consumer takes the result. MULTU/DIVU iterate WIDTH cycles in ITER.
// Build option: define SEQ_ALU_MULDIV_EN to include the iterative multiply /
// divide datapath; without it opcodes 12-13 complete in one cycle with zeros.
module seq_alu #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [3:0]       alu_op,
   input  logic [SHW-1:0]   shamt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             overflow,
   output logic             busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HOLD = 2'd2;
`ifdef SEQ_ALU_MULDIV_EN
   localparam logic [1:0] S_ITER = 2'd1;
`endif

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_SLL  = 4'd4;
   localparam logic [3:0] OP_SRL  = 4'd5;
   localparam logic [3:0] OP_SRA  = 4'd6;
   localparam logic [3:0] OP_LUI  = 4'd7;
   localparam logic [3:0] OP_SLT  = 4'd8;
   localparam logic [3:0] OP_SLTU = 4'd9;
   localparam logic [3:0] OP_XOR  = 4'd10;
   localparam logic [3:0] OP_NOR  = 4'd11;
`ifdef SEQ_ALU_MULDIV_EN
   localparam logic [3:0] OP_MULU = 4'd12;
   localparam logic [3:0] OP_DIVU = 4'd13;
`endif

   logic [1:0]       state;
   logic             accept;
   logic             start_md;
   logic [WIDTH-1:0] alu_res;
   logic             alu_ovf;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;

   assign in_ready = (state == S_IDLE) || ((state == S_HOLD) && out_ready);
   assign accept   = in_valid && in_ready;

`ifdef SEQ_ALU_MULDIV_EN
   logic [WIDTH-1:0] md_hi;
   logic [WIDTH-1:0] md_lo;
   logic [WIDTH-1:0] md_opnd;
   logic             md_div;
   logic             md_dz;
   logic [SHW-1:0]   cnt;
   logic             md_last;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_r;
   logic [WIDTH:0]   div_d;
   logic [WIDTH-1:0] hi_nxt;
   logic [WIDTH-1:0] lo_nxt;

   assign start_md = (alu_op == OP_MULU) || (alu_op == OP_DIVU);
   assign busy     = (state == S_ITER);
   assign md_last  = (cnt == SHW'(WIDTH - 1));
`else
   assign start_md = 1'b0;
   assign busy     = 1'b0;
`endif

   // Single-cycle result and signed overflow from the live operands.
   always_comb begin
      sum     = op_a + op_b;
      diff    = op_a - op_b;
      alu_res = '0;
      alu_ovf = 1'b0;
      case (alu_op)
         OP_ADD: begin
            alu_res = sum;
            alu_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = diff;
            alu_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
         end
         OP_AND:  alu_res = op_a & op_b;
         OP_OR:   alu_res = op_a | op_b;
         OP_SLL:  alu_res = op_b << shamt;
         OP_SRL:  alu_res = op_b >> shamt;
         OP_SRA:  alu_res = WIDTH'($signed(op_b) >>> shamt);
         OP_LUI:  alu_res = op_b << (WIDTH / 2);
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
         OP_XOR:  alu_res = op_a ^ op_b;
         OP_NOR:  alu_res = ~(op_a | op_b);
         default: begin
            alu_res = '0;
            alu_ovf = 1'b0;
         end
      endcase
   end

`ifdef SEQ_ALU_MULDIV_EN
   // One shift-add (multiply) or restoring-subtract (divide) step.
   // Multiply: {md_hi,md_lo} starts as {0,B} and shifts right with the carry.
   // Divide: md_hi is the partial remainder, md_lo shifts A out and quotient in.
   always_comb begin
      mul_sum = {1'b0, md_hi} + (md_lo[0] ? {1'b0, md_opnd} : '0);
      div_r   = {md_hi, md_lo[WIDTH-1]};
      div_d   = div_r - {1'b0, md_opnd};
      hi_nxt  = mul_sum[WIDTH:1];
      lo_nxt  = {mul_sum[0], md_lo[WIDTH-1:1]};
      if (md_div) begin
         if (!div_d[WIDTH]) begin
            hi_nxt = div_d[WIDTH-1:0];
            lo_nxt = {md_lo[WIDTH-2:0], 1'b1};
         end else begin
            hi_nxt = div_r[WIDTH-1:0];
            lo_nxt = {md_lo[WIDTH-2:0], 1'b0};
         end
      end
   end

   // Iterative datapath: load operands at acceptance, step once per ITER cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         md_hi   <= '0;
         md_lo   <= '0;
         md_opnd <= '0;
         md_div  <= 1'b0;
         md_dz   <= 1'b0;
         cnt     <= '0;
      end else if (accept && start_md) begin
         md_div  <= (alu_op == OP_DIVU);
         md_dz   <= (op_b == '0);
         md_hi   <= '0;
         md_lo   <= (alu_op == OP_DIVU) ? op_a : op_b;
         md_opnd <= (alu_op == OP_DIVU) ? op_b : op_a;
         cnt     <= '0;
      end else if (state == S_ITER) begin
         md_hi <= hi_nxt;
         md_lo <= lo_nxt;
         cnt   <= cnt + 1'b1;
      end
   end
`endif

   // Control FSM and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         out_valid <= 1'b0;
         result    <= '0;
         result_hi <= '0;
         overflow  <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_HOLD: begin
               if (accept) begin
                  if (start_md) begin
`ifdef SEQ_ALU_MULDIV_EN
                     state <= S_ITER;
`endif
                     out_valid <= 1'b0;
                     result    <= '0;
                     result_hi <= '0;
                     overflow  <= 1'b0;
                  end else begin
                     state     <= S_HOLD;
                     out_valid <= 1'b1;
                     result    <= alu_res;
                     result_hi <= '0;
                     overflow  <= alu_ovf;
                  end
               end else if ((state == S_HOLD) && out_ready) begin
                  state     <= S_IDLE;
                  out_valid <= 1'b0;
               end
            end
`ifdef SEQ_ALU_MULDIV_EN
            S_ITER: begin
               if (md_last) begin
                  state     <= S_HOLD;
                  out_valid <= 1'b1;
                  result    <= lo_nxt;
                  result_hi <= hi_nxt;
                  overflow  <= md_div && md_dz;
               end
            end
`endif
            default: begin
               state     <= S_IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
